// File: rtl/vga_pattern_gen_pkg.sv
// Shared types for the VGA test-pattern source: pattern selector, RGB444 pixel,
// colour-bar palette and the one-axis bounce step used by the box mover.
package vga_pkg;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_BOX      = 2'd3
    } pattern_mode_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Index 0 is the leftmost bar.
    localparam rgb_t [0:7] BAR_COLORS = {
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    // Returns {fwd, pos} after one bounce step; the turn-around consumes the step.
    function automatic logic [10:0] box_step(input logic [9:0] pos, input logic fwd,
                                             input logic [9:0] limit);
        if (fwd && pos == limit) return {1'b0, pos - 10'd1};
        if (!fwd && pos == 10'd0) return {1'b1, 10'd1};
        return fwd ? {1'b1, pos + 10'd1} : {1'b0, pos - 10'd1};
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle between the timing generator side and the pattern source.
interface vga_pattern_gen_if;
    logic       i_hs;
    logic       i_vs;
    logic       i_activeArea;
    logic [9:0] i_px;
    logic [9:0] i_py;
    logic [1:0] i_mode;
    logic       o_hs;
    logic       o_vs;
    logic [3:0] o_red;
    logic [3:0] o_green;
    logic [3:0] o_blue;

    modport master (
        output i_hs, i_vs, i_activeArea, i_px, i_py, i_mode,
        input  o_hs, o_vs, o_red, o_green, o_blue
    );

    modport slave (
        input  i_hs, i_vs, i_activeArea, i_px, i_py, i_mode,
        output o_hs, o_vs, o_red, o_green, o_blue
    );
endinterface

// File: rtl/vga_pattern_gen_box_mover.sv
// Bouncing-box position: steps one pixel per axis on every frame start and
// presents the post-step position in the frame-start cycle itself.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BOX_SIZE);

    logic [9:0]  x_q, y_q;
    logic        x_fwd, y_fwd;
    logic [10:0] x_nxt, y_nxt;

    assign x_nxt = box_step(x_q, x_fwd, X_MAX);
    assign y_nxt = box_step(y_q, y_fwd, Y_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            x_fwd <= 1'b1;
            y_fwd <= 1'b1;
        end else if (frame_start) begin
            {x_fwd, x_q} <= x_nxt;
            {y_fwd, y_q} <= y_nxt;
        end
    end

    assign box_x = frame_start ? x_nxt[9:0] : x_q;
    assign box_y = frame_start ? y_nxt[9:0] : y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage test-pattern source behind the VGA timing generator; sync and the
// active flag ride the same two stages so they stay aligned with the colour.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BAR_WIDTH  = 80,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_SIZE   = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    vga_pattern_gen_if.slave bus
);
    // Per-frame state
    logic          vs_prev, frame_start;
    pattern_mode_e mode_q, mode_cur;
    logic [7:0]    frame_cnt, frame_cur;
    logic [9:0]    box_x, box_y;

    // Reset clears vs_prev to 0, so leaving reset can never look like a falling edge.
    assign frame_start = vs_prev & ~bus.i_vs;
    assign mode_cur    = frame_start ? pattern_mode_e'(bus.i_mode) : mode_q;
    assign frame_cur   = frame_start ? frame_cnt + 8'd1 : frame_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vs_prev   <= 1'b0;
            mode_q    <= PAT_BARS;
            frame_cnt <= '0;
        end else begin
            vs_prev   <= bus.i_vs;
            mode_q    <= mode_cur;
            frame_cnt <= frame_cur;
        end
    end

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE)
    ) u_box (
        .clk         (i_clk),
        .rst_n       (i_reset_n),
        .frame_start (frame_start),
        .box_x       (box_x),
        .box_y       (box_y)
    );

    // Stage 1 terms
    logic [2:0]  bar_idx;
    logic [10:0] px_w, py_w, bx_w, by_w;
    logic        in_box;

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++)
            if (int'(bus.i_px) >= i * BAR_WIDTH) bar_idx = 3'(i);
    end

    assign px_w   = {1'b0, bus.i_px};
    assign py_w   = {1'b0, bus.i_py};
    assign bx_w   = {1'b0, box_x};
    assign by_w   = {1'b0, box_y};
    assign in_box = (px_w >= bx_w) && (px_w < bx_w + 11'(BOX_SIZE)) &&
                    (py_w >= by_w) && (py_w < by_w + 11'(BOX_SIZE));

    rgb_t          bar_s1, grad_s1;
    logic          chk_s1, box_s1, act_s1;
    pattern_mode_e mode_s1;
    logic [1:0]    hs_pipe, vs_pipe;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bar_s1  <= '0;
            grad_s1 <= '0;
            chk_s1  <= 1'b0;
            box_s1  <= 1'b0;
            act_s1  <= 1'b0;
            mode_s1 <= PAT_BARS;
            hs_pipe <= 2'b11;
            vs_pipe <= 2'b11;
        end else begin
            bar_s1  <= BAR_COLORS[bar_idx];
            grad_s1 <= {bus.i_px[8:5], bus.i_py[8:5], frame_cur[5:2]};
            chk_s1  <= bus.i_px[CHECK_LOG2] ^ bus.i_py[CHECK_LOG2];
            box_s1  <= in_box;
            act_s1  <= bus.i_activeArea;
            mode_s1 <= mode_cur;
            hs_pipe <= {hs_pipe[0], bus.i_hs};
            vs_pipe <= {vs_pipe[0], bus.i_vs};
        end
    end

    // Stage 2: select and blank
    rgb_t pix, rgb_q;

    always_comb begin
        pix = '0;
        case (mode_s1)
            PAT_BARS:     pix = bar_s1;
            PAT_CHECKER:  pix = chk_s1 ? rgb_t'(12'hFFF) : rgb_t'(12'h000);
            PAT_GRADIENT: pix = grad_s1;
            PAT_BOX:      pix = box_s1 ? rgb_t'(12'hFFF) : rgb_t'(12'h00F);
            default:      pix = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) rgb_q <= '0;
        else            rgb_q <= act_s1 ? pix : '0;
    end

    assign bus.o_hs    = hs_pipe[1];
    assign bus.o_vs    = vs_pipe[1];
    assign bus.o_red   = rgb_q.r;
    assign bus.o_green = rgb_q.g;
    assign bus.o_blue  = rgb_q.b;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen against a frame-level reference model
// (pattern from frame number and coordinates, box position as a triangle wave).
module tb_vga_pattern_gen;
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int BAR_WIDTH  = 80;
    localparam int CHECK_LOG2 = 5;
    localparam int BOX_SIZE   = 32;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    localparam exp_t RST_EXP = {1'b1, 1'b1, 12'h000};

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    vga_pattern_gen_if bus ();

    vga_pattern_gen #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .BAR_WIDTH  (BAR_WIDTH),
        .CHECK_LOG2 (CHECK_LOG2),
        .BOX_SIZE   (BOX_SIZE)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    exp_t       q[$];
    string      tag = "reset";
    int         nframes = 0;
    logic [1:0] mode_l = 2'd0;
    logic       prev_vs = 1'b0;

    function automatic int tri_pos(input int n, input int lim);
        int p;
        p = n % (2 * lim);
        return (p <= lim) ? p : 2 * lim - p;
    endfunction

    function automatic int clip(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [11:0] ref_color(input logic [1:0] m, input int x, input int y,
                                              input int n);
        int b, bx, by;
        logic [11:0] c;
        c = 12'h000;
        case (m)
            2'd0: begin
                b = x / BAR_WIDTH;
                if (b > 7) b = 7;
                case (b)
                    0: c = 12'hFFF; 1: c = 12'hFF0; 2: c = 12'h0FF; 3: c = 12'h0F0;
                    4: c = 12'hF0F; 5: c = 12'hF00; 6: c = 12'h00F; default: c = 12'h000;
                endcase
            end
            2'd1: c = ((((x >> CHECK_LOG2) ^ (y >> CHECK_LOG2)) & 1) != 0) ? 12'hFFF : 12'h000;
            2'd2: c = {4'((x >> 5) & 15), 4'((y >> 5) & 15), 4'(((n % 256) >> 2) & 15)};
            default: begin
                bx = tri_pos(n, H_ACTIVE - BOX_SIZE);
                by = tri_pos(n, V_ACTIVE - BOX_SIZE);
                c = (x >= bx && x < bx + BOX_SIZE && y >= by && y < by + BOX_SIZE) ?
                    12'hFFF : 12'h00F;
            end
        endcase
        return c;
    endfunction

    task automatic check_out(input exp_t e);
        checks++;
        assert (bus.o_hs === e.hs && bus.o_vs === e.vs &&
                {bus.o_red, bus.o_green, bus.o_blue} === e.rgb)
        else begin
            errors++;
            $error("FAIL %s: got hs=%b vs=%b rgb=%h, want hs=%b vs=%b rgb=%h", tag,
                   bus.o_hs, bus.o_vs, {bus.o_red, bus.o_green, bus.o_blue},
                   e.hs, e.vs, e.rgb);
        end
    endtask

    // Called just after a rising edge; applies one pixel and checks the output
    // that belongs to the pixel applied on the previous call.
    task automatic drive(input logic hs, input logic vs, input logic act, input int x,
                         input int y, input logic [1:0] m);
        exp_t e;
        bus.i_hs         = hs;
        bus.i_vs         = vs;
        bus.i_activeArea = act;
        bus.i_px         = 10'(x);
        bus.i_py         = 10'(y);
        bus.i_mode       = m;
        if (prev_vs && !vs) begin
            nframes++;
            mode_l = m;
        end
        prev_vs = vs;
        e.hs  = hs;
        e.vs  = vs;
        e.rgb = act ? ref_color(mode_l, x, y, nframes) : 12'h000;
        q.push_back(e);
        @(posedge clk);
        #1;
        check_out(q.pop_front());
    endtask

    task automatic rand_pixel(input logic [1:0] m);
        if ($urandom_range(3, 0) != 0)
            drive(1'($urandom_range(1, 0)), 1'b1, 1'b1, $urandom_range(H_ACTIVE - 1, 0),
                  $urandom_range(V_ACTIVE - 1, 0), m);
        else
            drive(1'($urandom_range(1, 0)), 1'b1, 1'b0, $urandom_range(1023, 0),
                  $urandom_range(1023, 0), m);
    endtask

    task automatic blank_px(input logic vs, input logic [1:0] m);
        drive(1'($urandom_range(1, 0)), vs, 1'b0, $urandom_range(1023, 0),
              $urandom_range(1023, 0), m);
    endtask

    // Compressed frame: porch, two vsync cycles, porch, then visible probes.
    // Mid-frame the requested mode wanders; only the vsync-edge value may count.
    task automatic frame(input logic [1:0] m, input int nrand);
        int bx, by;
        blank_px(1'b1, m);
        blank_px(1'b0, m);
        blank_px(1'b0, 2'($urandom_range(3, 0)));
        blank_px(1'b1, 2'($urandom_range(3, 0)));
        for (int i = 0; i < nrand; i++) rand_pixel(2'($urandom_range(3, 0)));
        if (m == 2'd3) begin
            bx = tri_pos(nframes, H_ACTIVE - BOX_SIZE);
            by = tri_pos(nframes, V_ACTIVE - BOX_SIZE);
            drive(1'b1, 1'b1, 1'b1, bx, by, m);
            drive(1'b1, 1'b1, 1'b1, bx + BOX_SIZE - 1, by + BOX_SIZE - 1, m);
            drive(1'b1, 1'b1, 1'b1, clip(bx - 1, H_ACTIVE - 1), by, m);
            drive(1'b1, 1'b1, 1'b1, clip(bx + BOX_SIZE, H_ACTIVE - 1), by, m);
            drive(1'b1, 1'b1, 1'b1, bx, clip(by - 1, V_ACTIVE - 1), m);
            drive(1'b1, 1'b1, 1'b1, bx + BOX_SIZE - 1, clip(by + BOX_SIZE, V_ACTIVE - 1), m);
        end
    endtask

    // One full 800-clock line with real hsync placement.
    task automatic full_line(input int y, input logic [1:0] m);
        for (int x = 0; x < 800; x++)
            drive(!(x >= 656 && x < 752), 1'b1, x < H_ACTIVE, x, y, m);
    endtask

    task automatic model_reset();
        nframes = 0;
        mode_l  = 2'd0;
        prev_vs = 1'b0;
        q.delete();
        q.push_back(RST_EXP);
    endtask

    initial begin
        bus.i_hs = 1'b1; bus.i_vs = 1'b1; bus.i_activeArea = 1'b0;
        bus.i_px = '0; bus.i_py = '0; bus.i_mode = 2'd0;

        #2 rst_n = 1'b0;
        #1 check_out(RST_EXP);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out(RST_EXP);
        rst_n = 1'b1;

        tag = "bars";
        frame(2'd0, 4);
        drive(1'b1, 1'b1, 1'b1, 0, 5, 2'd0);
        drive(1'b1, 1'b1, 1'b1, 80, 5, 2'd0);
        drive(1'b1, 1'b1, 1'b1, 559, 5, 2'd0);
        drive(1'b1, 1'b1, 1'b1, 639, 5, 2'd0);
        full_line(6, 2'd0);
        full_line(7, 2'd0);

        tag = "mode_change";
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b1, i * 32, 3, 2'd1);
        frame(2'd1, 10);
        drive(1'b1, 1'b1, 1'b1, 32, 0, 2'd1);
        drive(1'b1, 1'b1, 1'b1, 32, 32, 2'd1);

        tag = "box";
        for (int f = 0; f < 700; f++) frame(2'd3, 1);

        tag = "gradient";
        for (int f = 0; f < 300; f++) begin
            frame(2'd2, 1);
            drive(1'b1, 1'b1, 1'b1, 224, 96, 2'd2);
        end
        drive(1'b1, 1'b1, 1'b1, 0, 0, 2'd2);
        checks++;
        assert (bus.o_red === 4'd7 && bus.o_green === 4'd3)
        else begin
            errors++;
            $error("FAIL grad_224_96: got r=%h g=%h, want r=7 g=3", bus.o_red, bus.o_green);
        end

        tag = "blank";
        for (int f = 0; f < 40; f++) begin
            frame(2'($urandom_range(3, 0)), 0);
            for (int i = 0; i < 8; i++) blank_px(1'b1, 2'($urandom_range(3, 0)));
        end

        tag = "reset_mid";
        frame(2'd3, 5);
        drive(1'b1, 1'b1, 1'b1, 100, 50, 2'd3);
        #2 rst_n = 1'b0;
        #1 check_out(RST_EXP);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out(RST_EXP);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) rand_pixel(2'd3);
        drive(1'b1, 1'b1, 1'b1, 0, 0, 2'd3);
        drive(1'b1, 1'b1, 1'b1, 80, 0, 2'd3);
        tag = "reset_after";
        for (int f = 0; f < 3; f++) frame(2'd3, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
